// File: rtl/prores_enc_pkg.sv
// Shared types and widths for the ProRes DC encode path.
package prores_enc_pkg;

  localparam int COEFF_W = 20;
  localparam int LEN_W   = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dc_seq_state_t;

endpackage

// File: rtl/prores_dc_len_accum.sv
// Per-slice DC codeword-length accumulator (saturating) and length-report counter.
module prores_dc_len_accum #(
  parameter int LEN_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_len_valid,
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-1:0] o_sum_next,
  output logic [CNT_W-1:0] o_cnt_next
);

  logic [LEN_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W:0]   w_sum_wide;

  assign w_sum_wide = {1'b0, r_sum} + {1'b0, i_len};

  // Next values are exported so the sequencer can react in the same cycle as the last report.
  always_comb begin
    o_sum_next = r_sum;
    o_cnt_next = r_cnt;
    if (i_clear) begin
      o_sum_next = '0;
      o_cnt_next = '0;
    end else if (i_len_valid) begin
      o_sum_next = w_sum_wide[LEN_W] ? '1 : w_sum_wide[LEN_W-1:0];
      o_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else begin
      r_sum <= o_sum_next;
      r_cnt <= o_cnt_next;
    end
  end

endmodule

// File: rtl/prores_dc_encode_sequencer.sv
// Streams one slice's DC coefficients from the coefficient buffer into the DC entropy encoder.
// Optional DC_BITCOUNT_EN: count encoder lengths, drain on last length report, export slice DC bits.
module prores_dc_encode_sequencer #(
  parameter int COEFF_W     = prores_enc_pkg::COEFF_W,
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 8,
  parameter int LEN_W       = prores_enc_pkg::LEN_W,
  parameter int ENC_LATENCY = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_slice_base_addr,
  input  logic [CNT_W-1:0]   i_slice_blocks,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_coeff_rd_en,
  output logic [ADDR_W-1:0]  o_coeff_rd_addr,
  input  logic [COEFF_W-1:0] i_coeff_rd_data,
  output logic               o_enc_valid,
  output logic               o_enc_first,
  output logic [COEFF_W-1:0] o_enc_dc_coeff,
  input  logic               i_enc_len_valid,
  input  logic [LEN_W-1:0]   i_enc_len,
  output logic [LEN_W-1:0]   o_slice_dc_bits
);

  import prores_enc_pkg::*;

  dc_seq_state_t     r_state, w_next_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_blocks;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic              r_enc_valid;
  logic              r_enc_first;
  logic              w_slice_start;
  logic              w_drain_exit;

  assign w_slice_start = (r_state == IDLE) && i_start;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_next_state = (i_slice_blocks == '0) ? DONE : FETCH;
      FETCH:   if (r_rd_cnt == r_blocks - CNT_W'(1)) w_next_state = DRAIN;
      DRAIN:   if (w_drain_exit) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_blocks    <= '0;
      r_rd_cnt    <= '0;
      r_enc_valid <= 1'b0;
      r_enc_first <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_enc_valid <= (r_state == FETCH);
      r_enc_first <= (r_state == FETCH) && (r_rd_cnt == '0);
      if (w_slice_start) begin
        r_base   <= i_slice_base_addr;
        r_blocks <= i_slice_blocks;
        r_rd_cnt <= '0;
      end else if (r_state == FETCH) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
    end
  end

  assign o_busy          = (r_state != IDLE);
  assign o_done          = (r_state == DONE);
  assign o_coeff_rd_en   = (r_state == FETCH);
  assign o_coeff_rd_addr = o_coeff_rd_en ? r_base + ADDR_W'(r_rd_cnt) : '0;
  assign o_enc_valid     = r_enc_valid;
  assign o_enc_first     = r_enc_first;
  // The buffer registers its read data, so it lines up with the delayed read strobe.
  assign o_enc_dc_coeff  = r_enc_valid ? i_coeff_rd_data : '0;

`ifdef DC_BITCOUNT_EN
  logic [LEN_W-1:0] w_sum_next;
  logic [CNT_W-1:0] w_len_cnt_next;
  logic [LEN_W-1:0] r_slice_dc_bits;

  prores_dc_len_accum #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_len_accum (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_slice_start),
    .i_len_valid (i_enc_len_valid && (r_state != IDLE)),
    .i_len       (i_enc_len),
    .o_sum_next  (w_sum_next),
    .o_cnt_next  (w_len_cnt_next)
  );

  // Drain ends on the cycle the final length arrives, so done follows it directly.
  assign w_drain_exit = (w_len_cnt_next == r_blocks);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slice_dc_bits <= '0;
    end else if ((w_next_state == DONE) && (r_state != DONE)) begin
      r_slice_dc_bits <= w_sum_next;
    end
  end

  assign o_slice_dc_bits = r_slice_dc_bits;
`else
  localparam int DRAIN_W = $clog2(ENC_LATENCY + 2) + 1;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               w_unused_enc_len;

  // Counts 0..ENC_LATENCY+1: covers the read-data stage plus the encoder pipeline.
  assign w_drain_exit = (r_drain_cnt == DRAIN_W'(ENC_LATENCY + 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || w_slice_start) begin
      r_drain_cnt <= '0;
    end else if (r_state == DRAIN) begin
      r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
    end
  end

  assign w_unused_enc_len = ^{i_enc_len_valid, i_enc_len};
  assign o_slice_dc_bits  = '0;
`endif

endmodule

// File: tb/tb_prores_dc_encode_sequencer.sv
// Self-checking bench for prores_dc_encode_sequencer: table-driven slices plus reset/restart corner cases.
module tb_prores_dc_encode_sequencer;

  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 8;
  localparam int COEFF_W = 20;
  localparam int LEN_W   = 24;
  localparam int LAT     = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [CNT_W-1:0]   blocks;
  logic               busy, done, rd_en, enc_valid, enc_first;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COEFF_W-1:0] rd_data;
  logic [COEFF_W-1:0] enc_coeff;
  logic               len_valid;
  logic [LEN_W-1:0]   enc_len;
  logic [LEN_W-1:0]   slice_bits;

  always #5 clk = ~clk;

  prores_dc_encode_sequencer #(
    .COEFF_W(COEFF_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .LEN_W(LEN_W), .ENC_LATENCY(LAT)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_slice_base_addr(base_addr), .i_slice_blocks(blocks),
    .o_busy(busy), .o_done(done),
    .o_coeff_rd_en(rd_en), .o_coeff_rd_addr(rd_addr), .i_coeff_rd_data(rd_data),
    .o_enc_valid(enc_valid), .o_enc_first(enc_first), .o_enc_dc_coeff(enc_coeff),
    .i_enc_len_valid(len_valid), .i_enc_len(enc_len), .o_slice_dc_bits(slice_bits)
  );

  // Coefficient buffer: synchronous read, data one cycle after the strobe.
  logic [COEFF_W-1:0] mem [0:1023];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Encoder model: reports a length LAT cycles after each enc_valid, cycling through 6,1,9.
  int unsigned lens [3] = '{6, 1, 9};
  logic [LAT-1:0] v_pipe;
  int len_idx;
  always @(posedge clk) begin
    if (reset) v_pipe <= '0;
    else       v_pipe <= {v_pipe[LAT-2:0], enc_valid};
    if (start && !busy) len_idx <= 0;
    else if (len_valid) len_idx <= len_idx + 1;
  end
  assign len_valid = v_pipe[LAT-1];
  assign enc_len   = LEN_W'(lens[len_idx % 3]);

  // Cycle-stamped event log, sampled on the falling edge.
  int cyc = 0;
  int t0 = 0;
  bit logging = 1'b0;
  int rd_cyc[$];
  logic [ADDR_W-1:0] rd_adr[$];
  int enc_cyc[$];
  logic [COEFF_W-1:0] enc_dat[$];
  bit enc_fst[$];
  int done_cyc[$];
  int busy_n;
  logic [LEN_W-1:0] bits_at_done;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (logging) begin
      if (rd_en) begin rd_cyc.push_back(cyc - t0); rd_adr.push_back(rd_addr); end
      if (enc_valid) begin
        enc_cyc.push_back(cyc - t0); enc_dat.push_back(enc_coeff); enc_fst.push_back(enc_first);
      end
      if (done) begin done_cyc.push_back(cyc - t0); bits_at_done = slice_bits; end
      if (busy) busy_n++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    rd_cyc.delete(); rd_adr.delete(); enc_cyc.delete(); enc_dat.delete(); enc_fst.delete();
    done_cyc.delete(); busy_n = 0; bits_at_done = 'x;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  n;
    int                exp_done;  // done cycle with the timer-based drain
    bit                restart;   // re-pulse start mid-FETCH and in the done cycle
  } vec_t;

  vec_t vecs[6];

  // Starts a slice in cycle 0 (caller is just past a rising edge) and checks the logged events.
  task automatic run_slice(input vec_t v);
    int ed;
    int exp_sum;
    logic [ADDR_W-1:0] a;
    ed = v.exp_done;
`ifdef DC_BITCOUNT_EN
    if (v.n != 0) ed = ed - 1;
`endif
    exp_sum = 0;
    for (int i = 0; i < int'(v.n); i++) exp_sum += int'(lens[i % 3]);
    clear_log();
    start = 1'b1; base_addr = v.base; blocks = v.n; t0 = cyc; logging = 1'b1;
    @(posedge clk); #1;
    base_addr = 10'h155; blocks = 8'h77;
    for (int c = 1; c <= ed + 3; c++) begin
      start = v.restart && (c == 2 || c == ed);
      @(posedge clk); #1;
    end
    start = 1'b0; logging = 1'b0;

    check($sformatf("rd_count base=%0h n=%0d", v.base, v.n), rd_cyc.size(), 32'(v.n));
    for (int i = 0; i < int'(v.n) && i < rd_cyc.size(); i++) begin
      a = v.base + ADDR_W'(i);
      check($sformatf("rd_cycle[%0d] base=%0h", i, v.base), rd_cyc[i], 32'(1 + i));
      check($sformatf("rd_addr[%0d] base=%0h", i, v.base), 32'(rd_adr[i]), 32'(a));
    end
    check($sformatf("enc_count base=%0h n=%0d", v.base, v.n), enc_cyc.size(), 32'(v.n));
    for (int i = 0; i < int'(v.n) && i < enc_cyc.size(); i++) begin
      a = v.base + ADDR_W'(i);
      check($sformatf("enc_cycle[%0d] base=%0h", i, v.base), enc_cyc[i], 32'(2 + i));
      check($sformatf("enc_coeff[%0d] base=%0h", i, v.base), 32'(enc_dat[i]), 32'(mem[a]));
      check($sformatf("enc_first[%0d] base=%0h", i, v.base), 32'(enc_fst[i]), 32'(i == 0));
    end
    check($sformatf("done_count base=%0h", v.base), done_cyc.size(), 1);
    if (done_cyc.size() > 0)
      check($sformatf("done_cycle base=%0h", v.base), done_cyc[0], ed);
    check($sformatf("busy_cycles base=%0h", v.base), busy_n, ed);
    if (done_cyc.size() > 0) begin
`ifdef DC_BITCOUNT_EN
      check($sformatf("slice_dc_bits base=%0h", v.base), 32'(bits_at_done), exp_sum);
`else
      check($sformatf("slice_dc_bits base=%0h", v.base), 32'(bits_at_done), 0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = COEFF_W'(i * 37 + 3);
    mem[10'h010] = 20'd5;
    mem[10'h011] = 20'd7;
    mem[10'h012] = 20'd7;
    mem[10'h013] = -20'sd3;

    vecs[0] = '{10'h010, 8'd4, 11, 1'b0};  // basic slice, done at 3+4+4
    vecs[1] = '{10'h3FE, 8'd4, 11, 1'b0};  // address wrap
    vecs[2] = '{10'h200, 8'd0, 1,  1'b0};  // empty slice
    vecs[3] = '{10'h100, 8'd1, 8,  1'b0};  // single block
    vecs[4] = '{10'h040, 8'd6, 13, 1'b1};  // start re-pulsed while busy and in done cycle
    vecs[5] = '{10'h020, 8'd3, 10, 1'b0};  // lengths 6,1,9 -> 16 bits with bit counting

    reset = 1'b1; start = 1'b1; base_addr = 10'h3AA; blocks = 8'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_outputs", {27'd0, done, rd_en, enc_valid, enc_first, 1'b0}, 0);
    check("reset_addr_coeff", {2'b0, rd_addr, enc_coeff}, 0);
    check("reset_slice_bits", 32'(slice_bits), 0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    for (int k = 0; k < 6; k++) begin
      run_slice(vecs[k]);
      repeat (2) begin @(posedge clk); #1; end
    end

    // Reset during cycle 3 of an 8-block slice aborts it with no done pulse.
    clear_log();
    start = 1'b1; base_addr = 10'h080; blocks = 8'd8; t0 = cyc; logging = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_enc_valid", 32'(enc_valid), 0);
    check("abort_rd_en", 32'(rd_en), 0);
    repeat (16) begin @(posedge clk); #1; end
    logging = 1'b0;
    check("abort_no_done", done_cyc.size(), 0);
    check("abort_reads_before_reset", rd_cyc.size(), 3);
    run_slice('{10'h080, 8'd8, 15, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
